// File: rtl/mem_word_fetch.sv
// Byte-serial memory fetch: reads 1, 2 or 4 consecutive bytes big-endian and
// assembles them into a 32-bit word with optional sign extension.
module mem_word_fetch #(
  parameter int ADDR_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [7:0]        MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic [31:0]       Word,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [1:0] SZ_RSVD = 2'b11;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_memaddr;
  logic              r_memread;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [1:0]        w_state_nxt;
  logic [1:0]        w_idx_nxt;
  logic              w_accept;
  logic              w_reject;
  logic              w_last;
  logic [31:0]       w_shifted;

  // Index of the final byte for a given size code.
  function automatic logic [1:0] f_last_idx(input logic [1:0] size);
    case (size)
      2'b00:   f_last_idx = 2'd0;
      2'b01:   f_last_idx = 2'd1;
      2'b10:   f_last_idx = 2'd3;
      default: f_last_idx = 2'd0;
    endcase
  endfunction

  // Sign- or zero-extend a 1/2-byte result; 4-byte results pass through.
  function automatic logic [31:0] f_extend(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic        sext);
    case (size)
      2'b00:   f_extend = {{24{sext & word[7]}}, word[7:0]};
      2'b01:   f_extend = {{16{sext & word[15]}}, word[15:0]};
      default: f_extend = word;
    endcase
  endfunction

  assign w_last    = (r_idx == f_last_idx(r_size));
  assign w_shifted = {r_word[23:0], MemData};

  // Next-state, start decode and byte-index update.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Size == SZ_RSVD) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_idx_nxt   = 2'd0;
            w_state_nxt = S_ISSUE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPT;
      end
      S_CAPT: begin
        if (w_last) begin
          w_state_nxt = S_FIN;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and status strobes derived from the next state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_memread <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_FIN);
      r_err     <= w_reject;
      r_memread <= (w_state_nxt == S_ISSUE);
    end
  end

  // Request latch; only an accepted start may change the captured request.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_addr <= '0;
      r_size <= 2'b00;
      r_sext <= 1'b0;
    end else if (w_accept) begin
      r_addr <= Addr;
      r_size <= Size;
      r_sext <= SignExt;
    end else begin
      r_addr <= r_addr;
      r_size <= r_size;
      r_sext <= r_sext;
    end
  end

  // Memory address: loaded on each entry to ISSUE, held otherwise; wraps naturally.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_memaddr <= '0;
    end else if (w_state_nxt == S_ISSUE) begin
      r_memaddr <= w_accept ? Addr : (r_addr + ADDR_W'(w_idx_nxt));
    end else begin
      r_memaddr <= r_memaddr;
    end
  end

  // Word assembly: cleared on accept, shifted in per captured byte, extended on the last.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_word <= 32'd0;
    end else if (w_accept) begin
      r_word <= 32'd0;
    end else if (r_state == S_CAPT) begin
      r_word <= w_last ? f_extend(w_shifted, r_size, r_sext) : w_shifted;
    end else begin
      r_word <= r_word;
    end
  end

  assign MemAddr = r_memaddr;
  assign MemRead = r_memread;
  assign Word    = r_word;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Err     = r_err;

endmodule

// File: tb/tb_mem_word_fetch.sv
// Self-checking bench for mem_word_fetch: timeline-based reference model,
// directed corner cases and randomized traffic including async resets.
module tb_mem_word_fetch;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] Addr;
  logic [1:0]  Size;
  logic        SignExt;
  logic [7:0]  MemData = 8'd0;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [31:0] Word;
  logic        Busy;
  logic        Done;
  logic        Err;

  mem_word_fetch #(.ADDR_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Addr(Addr), .Size(Size),
    .SignExt(SignExt), .MemData(MemData), .MemAddr(MemAddr), .MemRead(MemRead),
    .Word(Word), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [7:0]  mem [256];
  logic [31:0] addr_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory: byte for an address read in cycle t is presented only in cycle t+1.
  bit         rd_pend = 1'b0;
  logic [7:0] ad_pend = 8'd0;
  always @(negedge Clock) begin
    rd_pend = MemRead;
    ad_pend = MemAddr[7:0];
  end
  always @(posedge Clock) begin
    #1;
    MemData = rd_pend ? mem[ad_pend] : 8'($urandom);
  end

  // Reference model: a fetch accepted at edge t0 occupies cycles t0..t0+2N.
  longint     cyc     = 0;
  bit         m_valid = 1'b0;
  bit         m_err   = 1'b0;
  longint     m_t0    = 0;
  int         m_n     = 1;
  logic [31:0] m_a    = 32'd0;
  bit         m_sx    = 1'b0;
  logic [7:0] m_bytes [4];

  always @(posedge Clock) begin
    if (Reset) begin
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (!m_valid || (cyc + 1 - m_t0) >= longint'(2 * m_n + 2)) begin
        if (Start && Size == 2'b11) begin
          m_err <= 1'b1;
        end else if (Start) begin
          m_valid <= 1'b1;
          m_t0    <= cyc + 1;
          m_n     <= (Size == 2'b00) ? 1 : (Size == 2'b01) ? 2 : 4;
          m_a     <= Addr;
          m_sx    <= SignExt;
          for (int i = 0; i < 4; i++) m_bytes[i] <= mem[8'(Addr[7:0] + 8'(i))];
        end
      end
    end
    cyc <= cyc + 1;
  end

  function automatic logic [31:0] model_word(input int k, input bit fin);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < k; i++) v = v * 32'd256 + 32'(m_bytes[i]);
    if (fin && m_n < 4 && m_sx && v[8 * m_n - 1]) v = v | ~((32'd1 << (8 * m_n)) - 32'd1);
    return v;
  endfunction

  // Compare every output against the model each cycle.
  always @(negedge Clock) begin
    logic [31:0] e_word, e_addr;
    logic        e_busy, e_rd, e_done, e_err;
    longint      d;
    int          hi;
    e_word = 32'd0; e_addr = 32'd0; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0; e_err = 1'b0;
    d = 0; hi = 0;
    if (!Reset) begin
      e_err = m_err;
      if (m_valid) begin
        d      = cyc - m_t0;
        e_busy = (d <= 2 * m_n);
        e_rd   = (d < 2 * m_n) && (d % 2 == 0);
        e_done = (d == 2 * m_n);
        hi     = (int'(d / 2) < m_n - 1) ? int'(d / 2) : m_n - 1;
        e_addr = m_a + 32'(hi);
        e_word = (d < 2 * m_n) ? model_word(int'(d / 2), 1'b0) : model_word(m_n, 1'b1);
      end
    end
    if (MemRead) addr_log.push_back(MemAddr);
    if (Done) done_cnt++;
    if (Err) err_cnt++;
    chk("cyc_word", Word, e_word);
    chk("cyc_memaddr", MemAddr, e_addr);
    chk("cyc_memread", 32'(MemRead), 32'(e_rd));
    chk("cyc_busy", 32'(Busy), 32'(e_busy));
    chk("cyc_done", 32'(Done), 32'(e_done));
    chk("cyc_err", 32'(Err), 32'(e_err));
  end

  task automatic do_fetch(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                          output logic [31:0] w, output int k);
    @(posedge Clock); #1;
    Start = 1'b1; Addr = a; Size = sz; SignExt = sx;
    addr_log.delete();
    @(posedge Clock); #1;
    Start = 1'b0; Addr = $urandom; Size = 2'($urandom); SignExt = 1'($urandom);
    k = 0;
    while (!Done && k < 20) begin
      @(posedge Clock); #1;
      k++;
    end
    chk("fetch_timeout", 32'(Done), 32'd1);
    w = Word;
  endtask

  logic [31:0] w;
  int          k;
  int          dc0, ec0;

  initial begin
    Reset = 1'b1; Start = 1'b0; Addr = 32'd0; Size = 2'b00; SignExt = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_word", Word, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_done_err", {30'd0, Done, Err}, 32'd0);
    Reset = 1'b0;

    // Big-endian 4-byte fetch
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    do_fetch(32'h100, 2'b10, 1'b0, w, k);
    chk("w4_word", w, 32'h12345678);
    chk("w4_edges", 32'(k), 32'd8);
    chk("w4_nreads", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("w4_addr", (i < addr_log.size()) ? addr_log[i] : 32'hDEADBEEF, 32'h100 + 32'(i));

    // Single byte sign/zero extension
    mem[8'h10] = 8'h80;
    do_fetch(32'h10, 2'b00, 1'b1, w, k);
    chk("b1_sx_word", w, 32'hFFFFFF80);
    chk("b1_edges", 32'(k), 32'd2);
    do_fetch(32'h10, 2'b00, 1'b0, w, k);
    chk("b1_zx_word", w, 32'h00000080);

    // Halfword sign extension
    mem[8'h20] = 8'h7F; mem[8'h21] = 8'hFF;
    do_fetch(32'h20, 2'b01, 1'b1, w, k);
    chk("h_pos_word", w, 32'h00007FFF);
    chk("h_edges", 32'(k), 32'd4);
    mem[8'h30] = 8'h80; mem[8'h31] = 8'h01;
    do_fetch(32'h30, 2'b01, 1'b1, w, k);
    chk("h_neg_word", w, 32'hFFFF8001);

    // Address wrap
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
    do_fetch(32'hFFFFFFFE, 2'b10, 1'b0, w, k);
    chk("wrap_word", w, 32'hA1B2C3D4);
    chk("wrap_a0", (addr_log.size() > 0) ? addr_log[0] : 32'h0BAD, 32'hFFFFFFFE);
    chk("wrap_a1", (addr_log.size() > 1) ? addr_log[1] : 32'h0BAD, 32'hFFFFFFFF);
    chk("wrap_a2", (addr_log.size() > 2) ? addr_log[2] : 32'h0BAD, 32'h00000000);
    chk("wrap_a3", (addr_log.size() > 3) ? addr_log[3] : 32'h0BAD, 32'h00000001);

    // Reserved size rejected
    @(posedge Clock); #1;
    Start = 1'b1; Size = 2'b11; Addr = 32'h44;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("rsv_err", 32'(Err), 32'd1);
    chk("rsv_busy", 32'(Busy), 32'd0);
    chk("rsv_word_kept", Word, 32'hA1B2C3D4);
    @(posedge Clock); #1;
    chk("rsv_err_pulse", 32'(Err), 32'd0);

    // Start during a fetch is ignored
    dc0 = done_cnt; ec0 = err_cnt;
    Start = 1'b1; Size = 2'b10; Addr = 32'h50; SignExt = 1'b0;
    @(posedge Clock); #1;
    for (int i = 0; i < 4; i++) begin
      Size = (i % 2 == 0) ? 2'b11 : 2'b00;
      Addr = $urandom;
      @(posedge Clock); #1;
    end
    Start = 1'b0;
    repeat (15) @(posedge Clock);
    #1;
    chk("busy_start_dones", 32'(done_cnt - dc0), 32'd1);
    chk("busy_start_errs", 32'(err_cnt - ec0), 32'd0);
    chk("busy_start_word", Word, {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]});

    // Asynchronous reset in CAPT aborts the fetch
    dc0 = done_cnt;
    Start = 1'b1; Size = 2'b10; Addr = 32'h60;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    chk("ar_pre_busy", 32'(Busy), 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("ar_busy", 32'(Busy), 32'd0);
    chk("ar_word", Word, 32'd0);
    chk("ar_memread", 32'(MemRead), 32'd0);
    chk("ar_memaddr", MemAddr, 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    repeat (12) @(posedge Clock);
    #1;
    chk("ar_no_done", 32'(done_cnt - dc0), 32'd0);
    mem[8'h60] = 8'h0F; mem[8'h61] = 8'hED; mem[8'h62] = 8'hCB; mem[8'h63] = 8'hA9;
    do_fetch(32'h60, 2'b10, 1'b1, w, k);
    chk("ar_after_word", w, 32'h0FEDCBA9);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clock); #1;
      Start   = ($urandom_range(0, 2) == 0);
      Size    = 2'($urandom);
      Addr    = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
      SignExt = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
      end
    end
    Start = 1'b0;
    repeat (12) @(posedge Clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
